// File: rtl/led_pattern_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : led_pattern_ctrl_pkg
// Brief  : Mode, colour and ping-pong state encodings for the LED pattern ctrl
// Rev    : 1.0  initial release
// ============================================================================
package led_pattern_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_ROTL  = 2'b00,
        MODE_ROTR  = 2'b01,
        MODE_PONG  = 2'b10,
        MODE_FLASH = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        COLOR_R   = 2'b00,
        COLOR_G   = 2'b01,
        COLOR_B   = 2'b10,
        COLOR_ALL = 2'b11
    } color_t;

    typedef enum logic [0:0] {
        S_UP   = 1'b0,
        S_DOWN = 1'b1
    } pp_state_t;

endpackage : led_pattern_ctrl_pkg
`default_nettype wire

// File: rtl/led_pattern_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : led_pattern_if
// Brief  : Strobe/control inputs and LED bank outputs of the pattern ctrl
// Rev    : 1.0  initial release
// ============================================================================
interface led_pattern_if
    import led_pattern_ctrl_pkg::*;
#(
    parameter int LED_WIDTH = 4
);
    logic                 i_valid;
    logic                 i_enable;
    mode_t                i_mode;
    color_t               i_color;
    logic [LED_WIDTH-1:0] o_led;
    logic [LED_WIDTH-1:0] o_led_g;
    logic [LED_WIDTH-1:0] o_led_b;
    logic                 o_wrap;

    modport master (
        output i_valid, i_enable, i_mode, i_color,
        input  o_led, o_led_g, o_led_b, o_wrap
    );

    modport slave (
        input  i_valid, i_enable, i_mode, i_color,
        output o_led, o_led_g, o_led_b, o_wrap
    );

endinterface : led_pattern_if
`default_nettype wire

// File: rtl/led_pattern_ctrl_color_mux.sv
`default_nettype none
// ============================================================================
// Module : led_color_mux
// Brief  : Registered router of the pattern onto the red/green/blue LED banks
// Rev    : 1.0  initial release
// ============================================================================
module led_color_mux
    import led_pattern_ctrl_pkg::*;
#(
    parameter int LED_WIDTH = 4
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire color_t               color,
    input  wire logic [LED_WIDTH-1:0] pat,
    output logic      [LED_WIDTH-1:0] led_r,
    output logic      [LED_WIDTH-1:0] led_g,
    output logic      [LED_WIDTH-1:0] led_b
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_r <= '0;
            led_g <= '0;
            led_b <= '0;
        end else begin
            led_r <= (color == COLOR_R || color == COLOR_ALL) ? pat : '0;
            led_g <= (color == COLOR_G || color == COLOR_ALL) ? pat : '0;
            led_b <= (color == COLOR_B || color == COLOR_ALL) ? pat : '0;
        end
    end

endmodule : led_color_mux
`default_nettype wire

// File: rtl/led_pattern_ctrl.sv
`default_nettype none
// ============================================================================
// Module : led_pattern_ctrl
// Brief  : Strobe-advanced LED pattern (rotate/ping-pong/flash) with bank select
// Rev    : 1.0  initial release
// ============================================================================
module led_pattern_ctrl
    import led_pattern_ctrl_pkg::*;
#(
    parameter int LED_WIDTH = 4
) (
    input  wire logic   clock,
    input  wire logic   i_reset,
    led_pattern_if.slave bus
);

    localparam logic [LED_WIDTH-1:0] c_pat_one = LED_WIDTH'(1);

    function automatic logic [LED_WIDTH-1:0] rotl(input logic [LED_WIDTH-1:0] p);
        logic [LED_WIDTH-1:0] r;
        for (int i = 0; i < LED_WIDTH; i++) begin
            r[(i + 1) % LED_WIDTH] = p[i];
        end
        return r;
    endfunction

    function automatic logic [LED_WIDTH-1:0] rotr(input logic [LED_WIDTH-1:0] p);
        logic [LED_WIDTH-1:0] r;
        for (int i = 0; i < LED_WIDTH; i++) begin
            r[i] = p[(i + 1) % LED_WIDTH];
        end
        return r;
    endfunction

    function automatic logic [LED_WIDTH-1:0] start_pat(input mode_t m);
        return (m == MODE_FLASH) ? '0 : c_pat_one;
    endfunction

    logic [LED_WIDTH-1:0] r_pat;
    pp_state_t            r_state;
    mode_t                r_mode;
    logic                 r_wrap_evt;
    logic                 r_wrap;

    logic [LED_WIDTH-1:0] w_rotl;
    logic [LED_WIDTH-1:0] w_rotr;
    logic                 w_adv;
    logic                 w_mode_chg;

    assign w_rotl     = rotl(r_pat);
    assign w_rotr     = rotr(r_pat);
    assign w_adv      = bus.i_valid & bus.i_enable;
    assign w_mode_chg = (bus.i_mode != r_mode);

    // r_wrap_evt marks the pattern step; r_wrap re-times it onto the LED update.
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            r_pat      <= start_pat(bus.i_mode);
            r_state    <= S_UP;
            r_mode     <= bus.i_mode;
            r_wrap_evt <= 1'b0;
            r_wrap     <= 1'b0;
        end else begin
            r_wrap_evt <= 1'b0;
            r_wrap     <= w_mode_chg ? 1'b0 : r_wrap_evt;
            if (w_mode_chg) begin
                r_pat   <= start_pat(bus.i_mode);
                r_state <= S_UP;
                r_mode  <= bus.i_mode;
            end else if (w_adv) begin
                case (r_mode)
                    MODE_ROTL: begin
                        r_pat      <= w_rotl;
                        r_wrap_evt <= r_pat[LED_WIDTH-1];
                    end
                    MODE_ROTR: begin
                        r_pat      <= w_rotr;
                        r_wrap_evt <= r_pat[0];
                    end
                    MODE_PONG: begin
                        if (r_state == S_UP) begin
                            r_pat <= w_rotl;
                            if (w_rotl[LED_WIDTH-1]) begin
                                r_state <= S_DOWN;
                            end
                        end else begin
                            r_pat <= w_rotr;
                            if (w_rotr[0]) begin
                                r_state    <= S_UP;
                                r_wrap_evt <= 1'b1;
                            end
                        end
                    end
                    MODE_FLASH: begin
                        r_pat      <= (&r_pat) ? '0 : '1;
                        r_wrap_evt <= &r_pat;
                    end
                endcase
            end
        end
    end

    led_color_mux #(
        .LED_WIDTH (LED_WIDTH)
    ) u_color_mux (
        .clk   (clock),
        .rst   (i_reset),
        .color (bus.i_color),
        .pat   (r_pat),
        .led_r (bus.o_led),
        .led_g (bus.o_led_g),
        .led_b (bus.o_led_b)
    );

    assign bus.o_wrap = r_wrap;

endmodule : led_pattern_ctrl
`default_nettype wire

// File: tb/tb_led_pattern_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_led_pattern_ctrl
// Brief  : Directed self-checking bench for led_pattern_ctrl (LED_WIDTH = 4)
// Rev    : 1.0  initial release
// ============================================================================
module tb_led_pattern_ctrl;
    import led_pattern_ctrl_pkg::*;

    logic clock;
    logic i_reset;
    int   n_vec;
    int   n_err;

    led_pattern_if #(.LED_WIDTH(4)) bus ();

    led_pattern_ctrl #(
        .LED_WIDTH (4)
    ) dut (
        .clock   (clock),
        .i_reset (i_reset),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    task automatic check_val(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One strobe, then wait for the LED update two edges later and check it.
    task automatic strobe_chk(input string tag, input logic [3:0] e_led, input logic e_wrap);
        bus.i_valid = 1'b1;
        tick();
        bus.i_valid = 1'b0;
        tick();
        check_val({tag, "_led"}, bus.o_led, e_led);
        check_val({tag, "_wrap"}, 4'(bus.o_wrap), 4'(e_wrap));
    endtask

    initial begin
        logic [3:0] rl_led  [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic       rl_wrap [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [3:0] pp_led  [6] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
        logic       pp_wrap [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        n_vec        = 0;
        n_err        = 0;
        i_reset      = 1'b1;
        bus.i_valid  = 1'b0;
        bus.i_enable = 1'b1;
        bus.i_mode   = MODE_ROTL;
        bus.i_color  = COLOR_R;
        tick();
        tick();
        check_val("rst_led",  bus.o_led,   4'b0000);
        check_val("rst_ledg", bus.o_led_g, 4'b0000);
        check_val("rst_ledb", bus.o_led_b, 4'b0000);
        check_val("rst_wrap", 4'(bus.o_wrap), 4'd0);

        i_reset = 1'b0;
        tick();
        check_val("rel_led",  bus.o_led,   4'b0001);
        check_val("rel_ledg", bus.o_led_g, 4'b0000);

        for (int i = 0; i < 4; i++) begin
            strobe_chk($sformatf("rotl%0d", i), rl_led[i], rl_wrap[i]);
        end
        tick();
        check_val("rotl_wrap_single", 4'(bus.o_wrap), 4'd0);

        strobe_chk("rotl_pre_rst", 4'b0010, 1'b0);
        #5 i_reset = 1'b1;
        #1;
        check_val("async_rst_led",  bus.o_led,   4'b0000);
        check_val("async_rst_ledb", bus.o_led_b, 4'b0000);
        i_reset = 1'b0;
        tick();
        check_val("async_rel_led", bus.o_led, 4'b0001);

        bus.i_mode = MODE_ROTR;
        tick();
        tick();
        check_val("rotr_start", bus.o_led, 4'b0001);
        strobe_chk("rotr0", 4'b1000, 1'b1);
        strobe_chk("rotr1", 4'b0100, 1'b0);

        bus.i_mode = MODE_PONG;
        tick();
        tick();
        check_val("pong_start", bus.o_led, 4'b0001);
        for (int i = 0; i < 6; i++) begin
            strobe_chk($sformatf("pong%0d", i), pp_led[i], pp_wrap[i]);
        end

        bus.i_mode = MODE_ROTL;
        tick();
        tick();
        bus.i_mode  = MODE_FLASH;
        bus.i_valid = 1'b1;
        tick();
        bus.i_valid = 1'b0;
        tick();
        check_val("mchg_led",  bus.o_led, 4'b0000);
        check_val("mchg_wrap", 4'(bus.o_wrap), 4'd0);
        strobe_chk("flash_on",  4'b1111, 1'b0);
        strobe_chk("flash_off", 4'b0000, 1'b1);

        bus.i_mode = MODE_ROTL;
        tick();
        tick();
        strobe_chk("en_pre", 4'b0010, 1'b0);
        bus.i_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            strobe_chk($sformatf("frozen%0d", i), 4'b0010, 1'b0);
        end
        bus.i_enable = 1'b1;

        bus.i_color = COLOR_ALL;
        tick();
        check_val("all_r", bus.o_led,   4'b0010);
        check_val("all_g", bus.o_led_g, 4'b0010);
        check_val("all_b", bus.o_led_b, 4'b0010);

        bus.i_color = COLOR_B;
        tick();
        check_val("blue_r", bus.o_led,   4'b0000);
        check_val("blue_g", bus.o_led_g, 4'b0000);
        check_val("blue_b", bus.o_led_b, 4'b0010);
        bus.i_valid = 1'b1;
        tick();
        bus.i_valid = 1'b0;
        tick();
        check_val("blue_adv_b", bus.o_led_b, 4'b0100);
        check_val("blue_adv_r", bus.o_led,   4'b0000);

        bus.i_color = COLOR_G;
        tick();
        check_val("green_g", bus.o_led_g, 4'b0100);
        check_val("green_b", bus.o_led_b, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_led_pattern_ctrl
`default_nettype wire
